fadd_align: RTL and testbench

Alignment stage of the single-precision adder/subtractor. It accepts two IEEE-754 binary32 operands and an add/sub control, unpacks them, and swaps them so the larger magnitude comes first. It then right-shifts the smaller mantissa by the exponent difference, using two `shift32` instances: one right shift for alignment, one left shift to recover the discarded bits. The registered result, including a sticky bit, feeds the mantissa add/normalise stage downstream.

---
 rtl/fadd_align.sv | 143 ++++++++++++++
 tb/tb_fadd_align.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_align.sv
// Alignment stage of the binary32 adder: unpack, order by magnitude, and
// right-align the smaller mantissa with a sticky bit, over a two-stage pipe.

module shift32 (
  input  logic [31:0] data,
  input  logic [5:0]  amt,
  input  logic        left,
  output logic [31:0] result
);
  // amt ranges 0..32; bit 5 set means the whole word is shifted out
  always_comb begin
    if (amt[5])
      result = '0;
    else if (left)
      result = data << amt[4:0];
    else
      result = data >> amt[4:0];
  end
endmodule

module fadd_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_exp,
  output logic [31:0] out_m_big,
  output logic [31:0] out_m_small,
  output logic        out_sticky,
  output logic        out_sign_big,
  output logic        out_eff_sub,
  output logic        out_swap,
  output logic        out_special
);
  logic [7:0]  exp_a, exp_b, eff_a, eff_b, eff_big, eff_small, diff;
  logic [31:0] m_a, m_b;
  logic        sign_a, sign_b, swap;
  logic [5:0]  shift_n;

  logic        s1_valid;
  logic [7:0]  s1_exp;
  logic [31:0] s1_m_big, s1_m_small;
  logic [5:0]  s1_shift;
  logic        s1_sign_big, s1_eff_sub, s1_swap, s1_special;

  logic        s2_load, s1_advance;
  logic [5:0]  left_amt;
  logic [31:0] small_shifted, discard;

  always_comb begin
    exp_a     = in_a[30:23];
    exp_b     = in_b[30:23];
    eff_a     = (exp_a == 8'd0) ? 8'd1 : exp_a;
    eff_b     = (exp_b == 8'd0) ? 8'd1 : exp_b;
    m_a       = {(exp_a != 8'd0), in_a[22:0], 8'h00};
    m_b       = {(exp_b != 8'd0), in_b[22:0], 8'h00};
    sign_a    = in_a[31];
    sign_b    = in_b[31] ^ in_sub;
    swap      = in_b[30:0] > in_a[30:0];
    eff_big   = swap ? eff_b : eff_a;
    eff_small = swap ? eff_a : eff_b;
    diff      = eff_big - eff_small;
    shift_n   = (diff >= 8'd32) ? 6'd32 : diff[5:0];
  end

  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s2_load;
  assign in_ready   = !s1_valid || s1_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_exp      <= '0;
      s1_m_big    <= '0;
      s1_m_small  <= '0;
      s1_shift    <= '0;
      s1_sign_big <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_swap     <= 1'b0;
      s1_special  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_exp      <= eff_big;
        s1_m_big    <= swap ? m_b : m_a;
        s1_m_small  <= swap ? m_a : m_b;
        s1_shift    <= shift_n;
        s1_sign_big <= swap ? sign_b : sign_a;
        s1_eff_sub  <= sign_a ^ sign_b;
        s1_swap     <= swap;
        s1_special  <= (&exp_a) || (&exp_b);
      end
    end
  end

  // The left shift by (32 - n) keeps exactly the bits the right shift dropped
  assign left_amt = 6'd32 - s1_shift;

  shift32 u_align (
    .data   (s1_m_small),
    .amt    (s1_shift),
    .left   (1'b0),
    .result (small_shifted)
  );

  shift32 u_discard (
    .data   (s1_m_small),
    .amt    (left_amt),
    .left   (1'b1),
    .result (discard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_exp      <= '0;
      out_m_big    <= '0;
      out_m_small  <= '0;
      out_sticky   <= 1'b0;
      out_sign_big <= 1'b0;
      out_eff_sub  <= 1'b0;
      out_swap     <= 1'b0;
      out_special  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_exp      <= s1_exp;
        out_m_big    <= s1_m_big;
        out_m_small  <= small_shifted;
        out_sticky   <= |discard;
        out_sign_big <= s1_sign_big;
        out_eff_sub  <= s1_eff_sub;
        out_swap     <= s1_swap;
        out_special  <= s1_special;
      end
    end
  end
endmodule

// File: tb/tb_fadd_align.sv
// Randomized bench for fadd_align with an in-bench arithmetic reference model
// and a per-cycle compare process tracking in-flight pairs and their age.

module tb_fadd_align;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [7:0]  out_exp;
  logic [31:0] out_m_big, out_m_small;
  logic        out_sticky, out_sign_big, out_eff_sub, out_swap, out_special;

  typedef struct packed {
    logic [7:0]  exp;
    logic [31:0] m_big;
    logic [31:0] m_small;
    logic        sticky;
    logic        sign_big;
    logic        eff_sub;
    logic        swap;
    logic        special;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   now = 0;
  res_t exp_q[$];
  int   acc_q[$];

  fadd_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_m_big(out_m_big),
    .out_m_small(out_m_small), .out_sticky(out_sticky), .out_sign_big(out_sign_big),
    .out_eff_sub(out_eff_sub), .out_swap(out_swap), .out_special(out_special)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t r;
    int ea, eb, ebig, esmall, d;
    logic [31:0] ma, mb, ms;
    logic [63:0] mask;
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    ma = {(a[30:23] != 0), a[22:0], 8'h00};
    mb = {(b[30:23] != 0), b[22:0], 8'h00};
    r.swap     = (b[30:0] > a[30:0]);
    ebig       = r.swap ? eb : ea;
    esmall     = r.swap ? ea : eb;
    d          = ebig - esmall;
    r.exp      = ebig[7:0];
    r.m_big    = r.swap ? mb : ma;
    ms         = r.swap ? ma : mb;
    r.m_small  = (d >= 32) ? 32'd0 : (ms >> d);
    mask       = (d >= 32) ? 64'hFFFF_FFFF : ((64'd1 << d) - 64'd1);
    r.sticky   = (({32'd0, ms} & mask) != 64'd0);
    r.sign_big = r.swap ? (b[31] ^ sub) : a[31];
    r.eff_sub  = a[31] ^ b[31] ^ sub;
    r.special  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return r;
  endfunction

  task automatic check_res(input string name, input res_t act, input res_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got exp=%h mb=%h ms=%h st=%b sg=%b es=%b sw=%b sp=%b, want exp=%h mb=%h ms=%h st=%b sg=%b es=%b sw=%b sp=%b",
               name, act.exp, act.m_big, act.m_small, act.sticky, act.sign_big, act.eff_sub, act.swap, act.special,
               req.exp, req.m_big, req.m_small, req.sticky, req.sign_big, req.eff_sub, req.swap, req.special);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, now);
    end
  endtask

  res_t dut_res;
  assign dut_res = '{exp: out_exp, m_big: out_m_big, m_small: out_m_small, sticky: out_sticky,
                     sign_big: out_sign_big, eff_sub: out_eff_sub, swap: out_swap, special: out_special};

  // Per-cycle compare: the oldest in-flight pair is visible once it is two cycles old
  always @(negedge clk) begin
    now++;
    if (rst) begin
      check_bit("reset out_valid", out_valid, 1'b0);
      check_res("reset outputs", dut_res, '0);
      exp_q.delete();
      acc_q.delete();
    end else begin
      check_bit("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      check_bit("out_valid", out_valid, (exp_q.size() > 0) && (now - acc_q[0] >= 2));
      if (out_valid && exp_q.size() > 0)
        check_res("out data", dut_res, exp_q[0]);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sub));
        acc_q.push_back(now);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic acc;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    if (!acc) begin
      errors++;
      $display("FAIL send timeout: in_ready stayed 0 for a=%h b=%h", a, b);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    logic [31:0] b;
    int e, mode;
    b = $urandom;
    mode = $urandom_range(0, 4);
    case (mode)
      1, 2: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 80)) - 40;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        b[30:23] = e[7:0];
      end
      3: b[30:0] = a[30:0];
      4: b[30:23] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
      default: ;
    endcase
    return b;
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        want;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] ra;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, '{8'h7F, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h3F800000, 32'h40000000, 1'b0, '{8'h80, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{32'h3F800000, 32'h40000000, 1'b1, '{8'h80, 32'h80000000, 32'h40000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[3] = '{32'h3F800000, 32'h30800000, 1'b0, '{8'h7F, 32'h80000000, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'h3F800000, 32'h30000000, 1'b0, '{8'h7F, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h3F800000, 32'h2B800000, 1'b0, '{8'h7F, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{32'h3F800000, 32'h3C000001, 1'b0, '{8'h7F, 32'h80000000, 32'h01000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{32'h3F800000, 32'h3B000001, 1'b0, '{8'h7F, 32'h80000000, 32'h00400000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{32'h00800000, 32'h00000001, 1'b0, '{8'h01, 32'h80000000, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{32'h7F800000, 32'h3F800000, 1'b0, '{8'hFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};

    foreach (vecs[i])
      check_res($sformatf("model vec%0d", i), model(vecs[i].a, vecs[i].b, vecs[i].sub), vecs[i].want);

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready after reset", in_ready, 1'b1);
    step();

    // Directed vectors, one at a time with a gap, then back-to-back
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub);
      repeat (3) step();
    end
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].sub);
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure: two pairs fill the pipe, the third must wait
    out_ready = 1'b0;
    send(vecs[3].a, vecs[3].b, 1'b0);
    send(vecs[6].a, vecs[6].b, 1'b0);
    in_a = vecs[7].a; in_b = vecs[7].b; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("stall in_ready", in_ready, 1'b0);
      check_res("stall holds first", dut_res, vecs[3].want);
      step();
    end
    out_ready = 1'b1;
    send(vecs[7].a, vecs[7].b, 1'b0);
    repeat (4) step();

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 15) == 0) ra[30:23] = 8'h00;
      in_a      = ra;
      in_b      = rand_b(ra);
      in_sub    = $urandom_range(0, 1);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        check_bit("mid reset out_valid", out_valid, 1'b0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("in_ready after mid reset", in_ready, 1'b1);
      end
      step();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pairs still pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
